dragon_hit_judge: RTL and testbench

Collision referee for the dragon enemy. Each `clk_22` tick it compares the dragon's on-screen box against the player missile and the robot, and raises `d_die`. That signal is wired straight back into the dragon mover's `life_state` input. It also tells the missile logic that its shot was consumed, flags robot damage, and keeps the dragon-kill score. A three-state handshake with the dragon's `show_valid` ensures each death is reported and scored exactly once, across the dead/cool-down/respawn cycle.

---
 rtl/dragon_hit_judge.sv | 135 +++++++++++++
 tb/tb_dragon_hit_judge.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dragon_hit_judge.sv
// Collision referee for the dragon: missile/robot box overlap -> registered d_die, hit pulses, kill score.
// One-cycle latency on all outputs; no backpressure, pause freezes all state and forces hit pulses low.
module dragon_hit_judge #(
  parameter int DRAGON_W  = 40,
  parameter int DRAGON_H  = 40,
  parameter int MISSILE_W = 8,
  parameter int MISSILE_H = 4,
  parameter int ROBOT_W   = 40,
  parameter int ROBOT_H   = 40,
  parameter int HOLD_MAX  = 7,
  parameter int SCORE_W   = 8
) (
  input  logic               clk_22,
  input  logic               rst,
  input  logic               pause,
  input  logic [9:0]         d_x,
  input  logic [9:0]         d_y,
  input  logic               show_valid,
  input  logic [9:0]         m_x,
  input  logic [9:0]         m_y,
  input  logic               m_valid,
  input  logic [9:0]         r_x,
  input  logic [9:0]         r_y,
  input  logic               r_valid,
  output logic               d_die,
  output logic               m_hit,
  output logic               r_hit,
  output logic [SCORE_W-1:0] score
);

  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
  localparam logic [10:0] DW = 11'(DRAGON_W);
  localparam logic [10:0] DH = 11'(DRAGON_H);
  localparam logic [10:0] MW = 11'(MISSILE_W);
  localparam logic [10:0] MH = 11'(MISSILE_H);
  localparam logic [10:0] RW = 11'(ROBOT_W);
  localparam logic [10:0] RH = 11'(ROBOT_H);

  typedef enum logic [1:0] {ARMED, KILL, WAIT_GONE} state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                timeout_q, timeout_d;
  logic                d_die_q, d_die_d;
  logic                m_hit_q, m_hit_d;
  logic                r_hit_q, r_hit_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                hit_m, hit_r;

  // Sums widened to 11 bits so a box near x/y=1023 cannot wrap; shared edges do not count.
  function automatic logic overlap(
    input logic [9:0]  ax, input logic [9:0]  ay,
    input logic [10:0] aw, input logic [10:0] ah,
    input logic [9:0]  bx, input logic [9:0]  by,
    input logic [10:0] bw, input logic [10:0] bh
  );
    return ({1'b0, ax} < ({1'b0, bx} + bw)) && ({1'b0, bx} < ({1'b0, ax} + aw)) &&
           ({1'b0, ay} < ({1'b0, by} + bh)) && ({1'b0, by} < ({1'b0, ay} + ah));
  endfunction

  assign hit_m = m_valid && overlap(d_x, d_y, DW, DH, m_x, m_y, MW, MH);
  assign hit_r = r_valid && overlap(d_x, d_y, DW, DH, r_x, r_y, RW, RH);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    timeout_d = timeout_q;
    score_d   = score_q;
    m_hit_d   = 1'b0;
    r_hit_d   = 1'b0;
    if (!pause) begin
      case (state_q)
        ARMED: begin
          if (!show_valid) begin
            state_d   = WAIT_GONE;
            timeout_d = 1'b0;
          end else if (hit_m) begin
            state_d = KILL;
            hold_d  = '0;
            m_hit_d = 1'b1;
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
          end else if (hit_r) begin
            state_d = KILL;
            hold_d  = '0;
            r_hit_d = 1'b1;
          end
        end
        KILL: begin
          hold_d = hold_q + HOLD_W'(1);
          if (!show_valid) begin
            state_d   = WAIT_GONE;
            timeout_d = 1'b0;
          end else if (hold_d == HOLD_LIM) begin
            state_d   = WAIT_GONE;
            timeout_d = 1'b1;
          end
        end
        WAIT_GONE: begin
          // After a timeout the dragon must be seen gone before a fresh life re-arms us.
          if (!show_valid)     timeout_d = 1'b0;
          else if (!timeout_q) state_d   = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end
    d_die_d = (state_d == KILL);
  end

  always_ff @(posedge clk_22) begin
    if (rst) begin
      state_q   <= ARMED;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      d_die_q   <= 1'b0;
      m_hit_q   <= 1'b0;
      r_hit_q   <= 1'b0;
      score_q   <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      d_die_q   <= d_die_d;
      m_hit_q   <= m_hit_d;
      r_hit_q   <= r_hit_d;
      score_q   <= score_d;
    end
  end

  assign d_die = d_die_q;
  assign m_hit = m_hit_q;
  assign r_hit = r_hit_q;
  assign score = score_q;

endmodule

// File: tb/tb_dragon_hit_judge.sv
// Directed bench for dragon_hit_judge; expected outputs queued with each stimulus step and checked after the edge.
module tb_dragon_hit_judge;

  logic       clk_22 = 1'b0;
  logic       rst, pause, show_valid, m_valid, r_valid;
  logic [9:0] d_x, d_y, m_x, m_y, r_x, r_y;
  logic       d_die, m_hit, r_hit;
  logic [7:0] score;

  typedef struct packed {
    logic       d;
    logic       m;
    logic       r;
    logic [7:0] s;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;
  int   es;

  dragon_hit_judge dut (
    .clk_22     (clk_22),
    .rst        (rst),
    .pause      (pause),
    .d_x        (d_x),
    .d_y        (d_y),
    .show_valid (show_valid),
    .m_x        (m_x),
    .m_y        (m_y),
    .m_valid    (m_valid),
    .r_x        (r_x),
    .r_y        (r_y),
    .r_valid    (r_valid),
    .d_die      (d_die),
    .m_hit      (m_hit),
    .r_hit      (r_hit),
    .score      (score)
  );

  always #5 clk_22 = ~clk_22;

  task automatic cyc(input logic ed, input logic em, input logic er, input logic [7:0] esc);
    exp_t e;
    exp_q.push_back({ed, em, er, esc});
    @(posedge clk_22);
    #1;
    e = exp_q.pop_front();
    step++;
    total++;
    assert (d_die === e.d) else begin
      bad++;
      $error("FAIL d_die step=%0d got=%b exp=%b", step, d_die, e.d);
    end
    total++;
    assert (m_hit === e.m) else begin
      bad++;
      $error("FAIL m_hit step=%0d got=%b exp=%b", step, m_hit, e.m);
    end
    total++;
    assert (r_hit === e.r) else begin
      bad++;
      $error("FAIL r_hit step=%0d got=%b exp=%b", step, r_hit, e.r);
    end
    total++;
    assert (score === e.s) else begin
      bad++;
      $error("FAIL score step=%0d got=%0d exp=%0d", step, score, e.s);
    end
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; show_valid = 1'b0; m_valid = 1'b0; r_valid = 1'b0;
    d_x = 10'd300; d_y = 10'd200; m_x = 10'd0; m_y = 10'd0; r_x = 10'd0; r_y = 10'd0;
    cyc(0, 0, 0, 8'd0);
    cyc(0, 0, 0, 8'd0);

    // missile kill, dragon acknowledges, re-arm
    rst = 1'b0; show_valid = 1'b1; m_valid = 1'b1; m_x = 10'd310; m_y = 10'd215;
    cyc(1, 1, 0, 8'd1);
    cyc(1, 0, 0, 8'd1);
    show_valid = 1'b0;
    cyc(0, 0, 0, 8'd1);
    cyc(0, 0, 0, 8'd1);
    show_valid = 1'b1; m_x = 10'd340;
    cyc(0, 0, 0, 8'd1);
    cyc(0, 0, 0, 8'd1);
    m_x = 10'd339;
    cyc(1, 1, 0, 8'd2);
    show_valid = 1'b0;
    cyc(0, 0, 0, 8'd2);
    show_valid = 1'b1; m_valid = 1'b0;
    cyc(0, 0, 0, 8'd2);

    // simultaneous overlap: missile wins
    m_valid = 1'b1; m_x = 10'd310; m_y = 10'd215;
    r_valid = 1'b1; r_x = 10'd320; r_y = 10'd210;
    cyc(1, 1, 0, 8'd3);
    show_valid = 1'b0;
    cyc(0, 0, 0, 8'd3);
    show_valid = 1'b1; m_valid = 1'b0;
    cyc(0, 0, 0, 8'd3);

    // robot-only hit followed by timeout with show_valid stuck high
    cyc(1, 0, 1, 8'd3);
    repeat (6) cyc(1, 0, 0, 8'd3);
    cyc(0, 0, 0, 8'd3);
    repeat (3) cyc(0, 0, 0, 8'd3);
    show_valid = 1'b0;
    cyc(0, 0, 0, 8'd3);
    show_valid = 1'b1;
    cyc(0, 0, 0, 8'd3);
    cyc(1, 0, 1, 8'd3);

    // pause inside KILL freezes d_die and the hold counter
    pause = 1'b1; m_valid = 1'b1;
    repeat (8) cyc(1, 0, 0, 8'd3);
    pause = 1'b0; m_valid = 1'b0;
    repeat (6) cyc(1, 0, 0, 8'd3);
    cyc(0, 0, 0, 8'd3);
    show_valid = 1'b0;
    cyc(0, 0, 0, 8'd3);
    r_valid = 1'b0; m_valid = 1'b1; show_valid = 1'b1;
    cyc(0, 0, 0, 8'd3);
    pause = 1'b1;
    repeat (2) cyc(0, 0, 0, 8'd3);
    pause = 1'b0;

    // drive the score up to saturation
    es = 3;
    while (es < 255) begin
      cyc(1, 1, 0, 8'(es + 1));
      es++;
      show_valid = 1'b0;
      cyc(0, 0, 0, 8'(es));
      show_valid = 1'b1;
      cyc(0, 0, 0, 8'(es));
    end
    cyc(1, 1, 0, 8'd255);

    // reset mid-KILL re-arms and detects on the following edge
    rst = 1'b1;
    cyc(0, 0, 0, 8'd0);
    rst = 1'b0;
    cyc(1, 1, 0, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
